// File: rtl/commit_rob.sv
// In-order commit reorder buffer: retires heads, maintains the committed rename map, drives flushes.
// Define COMMIT_PERF_CNT_EN to build the retired/abort performance counters.
module commit_rob #(
  parameter int RNDEPTH = 4,
  parameter int ROB_DP  = 8,
  localparam int RNBIT  = $clog2(RNDEPTH),
  localparam int AW     = $clog2(ROB_DP),
  localparam int NSEL   = 32 * RNDEPTH
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                dsp_valid,
  output logic                dsp_ready,
  input  logic [63:0]         dsp_pc,
  input  logic [4+RNBIT:0]    dsp_rd0,
  input  logic                dsp_isBranch,
  input  logic                dsp_isSynExcept,
  input  logic [NSEL-1:0]     wbLog_qout,
  input  logic                brq_valid,
  input  logic                brq_misPredict,
  output logic                brq_pop,
  input  logic                isAsynExcept,
  output logic [RNBIT*32-1:0] archi_X_qout,
  output logic [NSEL-1:0]     rn_rst_mask,
`ifdef COMMIT_PERF_CNT_EN
  output logic [63:0]         perf_retired,
  output logic [31:0]         perf_abort,
`endif
  output logic                commit_valid,
  output logic [63:0]         commit_pc,
  output logic                flush,
  output logic [1:0]          flush_cause,
  output logic [63:0]         flush_pc
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e           state_q;
  logic [AW:0]      head_q, head_d, tail_q, tail_d;
  logic [63:0]      pc_mem [ROB_DP];
  logic [4+RNBIT:0] rd_mem [ROB_DP];
  logic [ROB_DP-1:0] br_mem, se_mem;
  logic [RNBIT-1:0] map_q [32];
  logic [RNBIT-1:0] map_d [32];

  logic             running, empty, full, push;
  logic [AW-1:0]    hIdx, tIdx;
  logic [4:0]       hArch;
  logic [RNBIT-1:0] hPhy;
  logic [63:0]      hPc;
  logic             hBr, hSe;
  logic             headReady, doAsync, doSync, doCommit, doMisp, abort;
  logic [4+RNBIT:0] bitSel;

  assign running = (state_q == RUN);
  assign empty   = (head_q == tail_q);
  assign full    = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign hIdx    = head_q[AW-1:0];
  assign tIdx    = tail_q[AW-1:0];
  assign hArch   = rd_mem[hIdx][4+RNBIT:RNBIT];
  assign hPhy    = rd_mem[hIdx][RNBIT-1:0];
  assign hPc     = pc_mem[hIdx];
  assign hBr     = br_mem[hIdx];
  assign hSe     = se_mem[hIdx];

  // The {arch, phy} field doubles as the wbLog bit select because RNDEPTH is a power of two.
  assign headReady = running && !empty &&
                     (hSe || ((wbLog_qout[rd_mem[hIdx]] || hArch == 5'd0) && (!hBr || brq_valid)));
  assign doAsync   = running && !empty && isAsynExcept;
  assign doSync    = headReady && hSe && !doAsync;
  assign doCommit  = headReady && !hSe && !doAsync;
  assign doMisp    = doCommit && hBr && brq_misPredict;
  assign abort     = doAsync || doSync || doMisp;

  assign dsp_ready    = RSTn && running && !full;
  assign push         = dsp_valid && dsp_ready && !abort;
  assign commit_valid = doCommit;
  assign commit_pc    = doCommit ? hPc : 64'd0;
  assign brq_pop      = doCommit && hBr;
  assign flush        = abort;

  assign head_d = abort ? tail_q : head_q + (AW+1)'(doCommit);
  assign tail_d = tail_q + (AW+1)'(push);

  always_comb begin
    flush_cause = 2'b00;
    flush_pc    = 64'd0;
    if (doAsync) begin
      flush_cause = 2'b11;
      flush_pc    = hPc;
    end else if (doSync) begin
      flush_cause = 2'b10;
      flush_pc    = hPc;
    end else if (doMisp) begin
      flush_cause = 2'b01;
      flush_pc    = hPc + 64'd4;
    end
  end

  // On abort every rename copy except the surviving committed mapping is released.
  always_comb begin
    map_d       = map_q;
    rn_rst_mask = '0;
    bitSel      = '0;
    if (doCommit && hArch != 5'd0) begin
      map_d[hArch] = hPhy;
      rn_rst_mask[{hArch, map_q[hArch]}] = 1'b1;
    end
    if (abort) begin
      for (int r = 1; r < 32; r++) begin
        for (int p = 0; p < RNDEPTH; p++) begin
          bitSel = {5'(r), RNBIT'(p)};
          if (RNBIT'(p) != map_d[5'(r)]) rn_rst_mask[bitSel] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_map
    assign archi_X_qout[g*RNBIT +: RNBIT] = map_q[g];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      map_q   <= '{default: '0};
    end else begin
      state_q <= abort ? FLUSH : RUN;
      head_q  <= head_d;
      tail_q  <= tail_d;
      map_q   <= map_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[tIdx] <= dsp_pc;
      rd_mem[tIdx] <= dsp_rd0;
      br_mem[tIdx] <= dsp_isBranch;
      se_mem[tIdx] <= dsp_isSynExcept;
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      perf_retired <= '0;
      perf_abort   <= '0;
    end else begin
      perf_retired <= perf_retired + 64'(doCommit);
      perf_abort   <= perf_abort + 32'(abort);
    end
  end
`endif

endmodule

// File: tb/tb_commit_rob.sv
// Bench for commit_rob: directed scenarios plus random traffic, checked against a queue-based
// model of the reorder buffer and committed rename map.
module tb_commit_rob;
  localparam int RNDEPTH = 4;
  localparam int ROB_DP  = 8;
  localparam int RNBIT   = 2;
  localparam int NSEL    = 32 * RNDEPTH;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic               dsp_valid;
  logic               dsp_ready;
  logic [63:0]        dsp_pc;
  logic [4+RNBIT:0]   dsp_rd0;
  logic               dsp_isBranch;
  logic               dsp_isSynExcept;
  logic [NSEL-1:0]    wbLog_qout;
  logic               brq_valid;
  logic               brq_misPredict;
  logic               brq_pop;
  logic               isAsynExcept;
  logic [RNBIT*32-1:0] archi_X_qout;
  logic [NSEL-1:0]    rn_rst_mask;
  logic               commit_valid;
  logic [63:0]        commit_pc;
  logic               flush;
  logic [1:0]         flush_cause;
  logic [63:0]        flush_pc;

  commit_rob #(.RNDEPTH(RNDEPTH), .ROB_DP(ROB_DP)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_pc(dsp_pc), .dsp_rd0(dsp_rd0),
    .dsp_isBranch(dsp_isBranch), .dsp_isSynExcept(dsp_isSynExcept),
    .wbLog_qout(wbLog_qout), .brq_valid(brq_valid), .brq_misPredict(brq_misPredict),
    .brq_pop(brq_pop), .isAsynExcept(isAsynExcept), .archi_X_qout(archi_X_qout),
    .rn_rst_mask(rn_rst_mask), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .flush(flush), .flush_cause(flush_cause), .flush_pc(flush_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    int          arch;
    int          phy;
    bit          br;
    bit          se;
  } entry_t;

  entry_t      robQ[$];
  int          mapM[32];
  bit          inFlush;
  int          checks = 0;
  int          errors = 0;
  logic        lastCommit, lastFlush;
  logic [1:0]  lastCause;
  logic [63:0] lastFlushPc;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    robQ.delete();
    foreach (mapM[i]) mapM[i] = 0;
    inFlush = 0;
  endtask

  task automatic idleInputs();
    dsp_valid = 0; dsp_pc = '0; dsp_rd0 = '0; dsp_isBranch = 0; dsp_isSynExcept = 0;
    brq_valid = 0; brq_misPredict = 0; isAsynExcept = 0;
  endtask

  // One clock cycle: predict from the model, compare at the falling edge, then advance the model.
  task automatic applyStimulus();
    logic        expReady, expCv, expPop, expFlush;
    logic [1:0]  expCause;
    logic [63:0] expCpc, expFpc;
    logic [127:0] expMask;
    logic [63:0] expArch;
    bit          doCommit, doAbort;
    entry_t      h, n;
    @(negedge CLK);
    expCv = 0; expPop = 0; expCause = 0; expCpc = 0; expFpc = 0; expMask = 0;
    doCommit = 0; doAbort = 0;
    for (int r = 0; r < 32; r++) expArch[r*RNBIT +: RNBIT] = RNBIT'(mapM[r]);
    expReady = !inFlush && robQ.size() < ROB_DP;
    if (!inFlush && robQ.size() > 0) begin
      h = robQ[0];
      if (isAsynExcept) begin
        doAbort = 1; expCause = 2'b11; expFpc = h.pc;
      end else if (h.se) begin
        doAbort = 1; expCause = 2'b10; expFpc = h.pc;
      end else if ((wbLog_qout[h.arch*RNDEPTH + h.phy] || h.arch == 0) && (!h.br || brq_valid)) begin
        doCommit = 1; expCv = 1; expCpc = h.pc; expPop = h.br;
        if (h.arch != 0) begin
          expMask[h.arch*RNDEPTH + mapM[h.arch]] = 1'b1;
          mapM[h.arch] = h.phy;
        end
        if (h.br && brq_misPredict) begin
          doAbort = 1; expCause = 2'b01; expFpc = h.pc + 64'd4;
        end
      end
    end
    if (doAbort)
      for (int r = 1; r < 32; r++)
        for (int p = 0; p < RNDEPTH; p++)
          if (p != mapM[r]) expMask[r*RNDEPTH + p] = 1'b1;
    expFlush = doAbort;
    checkOutput("dsp_ready", 128'(dsp_ready), 128'(expReady));
    checkOutput("commit_valid", 128'(commit_valid), 128'(expCv));
    checkOutput("commit_pc", 128'(commit_pc), 128'(expCpc));
    checkOutput("brq_pop", 128'(brq_pop), 128'(expPop));
    checkOutput("flush", 128'(flush), 128'(expFlush));
    checkOutput("flush_cause", 128'(flush_cause), 128'(expCause));
    checkOutput("flush_pc", 128'(flush_pc), 128'(expFpc));
    checkOutput("rn_rst_mask", rn_rst_mask, expMask);
    checkOutput("archi_X_qout", 128'(archi_X_qout), 128'(expArch));
    lastCommit = commit_valid; lastFlush = flush; lastCause = flush_cause; lastFlushPc = flush_pc;
    if (doCommit) void'(robQ.pop_front());
    if (dsp_valid && expReady && !doAbort) begin
      n.pc = dsp_pc; n.arch = int'(dsp_rd0[4+RNBIT:RNBIT]); n.phy = int'(dsp_rd0[RNBIT-1:0]);
      n.br = dsp_isBranch; n.se = dsp_isSynExcept;
      robQ.push_back(n);
    end
    if (doAbort) robQ.delete();
    inFlush = doAbort;
    @(posedge CLK);
    #1;
  endtask

  task automatic pushEntry(input logic [63:0] pc, input int arch, input int phy, input bit br, input bit se);
    dsp_valid = 1; dsp_pc = pc; dsp_rd0 = {5'(arch), RNBIT'(phy)};
    dsp_isBranch = br; dsp_isSynExcept = se;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    dsp_valid = 0;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    RSTn = 0;
    idleInputs();
    wbLog_qout = '0;
    modelReset();
    #12;
    checkOutput("reset_dsp_ready", 128'(dsp_ready), 128'(0));
    checkOutput("reset_commit", 128'(commit_valid), 128'(0));
    checkOutput("reset_flush", 128'(flush), 128'(0));
    checkOutput("reset_mask", rn_rst_mask, 128'(0));
    checkOutput("reset_map", 128'(archi_X_qout), 128'(0));
    RSTn = 1;
    @(posedge CLK);
    #1;

    $display("[TB] three-commit sequence");
    pushEntry(64'h100, 1, 1, 0, 0);
    pushEntry(64'h104, 2, 1, 0, 0);
    pushEntry(64'h108, 3, 1, 0, 0);
    wbLog_qout[5] = 1; wbLog_qout[9] = 1; wbLog_qout[13] = 1;
    idleCycles(3);
    checkOutput("map_arch1to3", 128'(archi_X_qout[7:0]), 128'(8'h54));
    idleCycles(1);

    $display("[TB] fill, full and wrap");
    wbLog_qout = '0;
    for (int i = 0; i < ROB_DP; i++) pushEntry(64'h400 + 64'(i*4), 4 + i, 2, 0, 0);
    pushEntry(64'h4F0, 20, 1, 0, 0);
    wbLog_qout[18] = 1;
    applyStimulus();
    applyStimulus();
    wbLog_qout = '1;
    for (int i = 0; i < 6; i++) pushEntry(64'h500 + 64'(i*4), 12 + i, 3, 0, 0);
    idleCycles(12);

    $display("[TB] mispredicted branch");
    pushEntry(64'h1000, 5, 2, 1, 0);
    brq_valid = 1; brq_misPredict = 1;
    pushEntry(64'h1100, 9, 1, 0, 0);
    checkOutput("misp_commit", 128'(lastCommit), 128'(1));
    checkOutput("misp_cause", 128'(lastCause), 128'(2'b01));
    checkOutput("misp_pc", 128'(lastFlushPc), 128'(64'h1004));
    brq_valid = 0; brq_misPredict = 0;
    applyStimulus();
    idleCycles(3);

    $display("[TB] async exception over ready head");
    pushEntry(64'h2000, 6, 1, 0, 0);
    isAsynExcept = 1;
    pushEntry(64'h2004, 7, 2, 0, 1);
    checkOutput("async_commit", 128'(lastCommit), 128'(0));
    checkOutput("async_cause", 128'(lastCause), 128'(2'b11));
    checkOutput("async_pc", 128'(lastFlushPc), 128'(64'h2000));
    idleCycles(3);
    isAsynExcept = 0;

    $display("[TB] sync exception then reset during flush");
    pushEntry(64'h3000, 8, 3, 0, 1);
    idleCycles(1);
    checkOutput("sync_cause", 128'(lastCause), 128'(2'b10));
    checkOutput("sync_pc", 128'(lastFlushPc), 128'(64'h3000));
    RSTn = 0;
    #2;
    checkOutput("rst_flush", 128'(flush), 128'(0));
    checkOutput("rst_commit", 128'(commit_valid), 128'(0));
    checkOutput("rst_ready", 128'(dsp_ready), 128'(0));
    checkOutput("rst_mask", rn_rst_mask, 128'(0));
    checkOutput("rst_map", 128'(archi_X_qout), 128'(0));
    modelReset();
    @(negedge CLK);
    RSTn = 1;
    @(posedge CLK);
    #1;
    pushEntry(64'h3100, 3, 2, 0, 0);
    idleCycles(2);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      dsp_valid       = ($urandom_range(0, 3) != 0);
      dsp_pc          = {$urandom, $urandom} & ~64'd3;
      dsp_rd0         = 7'($urandom);
      dsp_isBranch    = ($urandom_range(0, 5) == 0);
      dsp_isSynExcept = ($urandom_range(0, 24) == 0);
      wbLog_qout      = {$urandom, $urandom, $urandom, $urandom};
      brq_valid       = ($urandom_range(0, 1) == 1);
      brq_misPredict  = ($urandom_range(0, 3) == 0);
      isAsynExcept    = ($urandom_range(0, 39) == 0);
      applyStimulus();
    end
    idleInputs();
    wbLog_qout = '1;
    idleCycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_rob.md
COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 SHALL have parameter RNDEPTH, default 4, rename copies per architectural register (power of two, >=2); RNBIT = clog2(RNDEPTH).
REQ-002 SHALL have parameter ROB_DP, default 8, reorder-buffer entries (power of two, >=2).
REQ-003 SHALL have one clock and asynchronous active-low reset, named CLK and RSTn: CLK input 1, rising-edge clock; RSTn input 1, async active-low reset.
REQ-004 The dispatch port SHALL be: dsp_valid input 1; dsp_ready output 1; dsp_pc input 64; dsp_rd0 input 5+RNBIT as {arch[4:0], phy[RNBIT-1:0]}; dsp_isBranch input 1; dsp_isSynExcept input 1.
REQ-005 The writeback and branch inputs SHALL be: wbLog_qout input 32*RNDEPTH, written-back flags, bit SEL = arch*RNDEPTH+phy; brq_valid input 1, branch-result FIFO non-empty; brq_misPredict input 1, head branch result.
REQ-006 The remaining control ports SHALL be: brq_pop output 1, pops branch-result FIFO; isAsynExcept input 1, level interrupt request.
REQ-007 The architectural map port SHALL be: archi_X_qout output RNBIT*32, committed phy index per arch register, field r at [r*RNBIT +: RNBIT].
REQ-008 The free-mask port SHALL be: rn_rst_mask output 32*RNDEPTH, one-cycle per-bit clears for wbLog and rename-buffer-used.
REQ-009 The commit port SHALL be: commit_valid output 1; commit_pc output 64.
REQ-010 The flush port SHALL be: flush output 1; flush_cause output 2 (01 mispredict, 10 sync except, 11 async except); flush_pc output 64.

Function
REQ-011 SHALL hold ROB_DP entries {pc, rd0, isBranch, isSynExcept} in a circular buffer with head/tail pointers of clog2(ROB_DP)+1 bits, wrap bit distinguishing full from empty.
REQ-012 SHALL use a two-state FSM: RUN and FLUSH; reset state RUN.
REQ-013 In RUN, dsp_ready SHALL be 1 iff not full; push on dsp_valid & dsp_ready writes tail and advances it at the edge.
REQ-014 The head SHALL be ready when non-empty and, by case:
- isSynExcept set: ready immediately, no writeback needed;
- otherwise: wbLog_qout[SEL]=1 or arch=0;
- isBranch set: additionally brq_valid=1.
REQ-015 Priority at a ready or non-empty head SHALL be: async except, sync except, branch mispredict, normal commit; evaluated combinationally, registered effects at next edge.
REQ-016 isAsynExcept with non-empty ROB in RUN SHALL abort before the head executes: no commit, flush=1, cause 11, flush_pc = head pc. With empty ROB it SHALL wait.
REQ-017 Ready head with isSynExcept SHALL abort: no arch update, cause 10, flush_pc = head pc; brq_pop=0.
REQ-018 Normal commit SHALL be a single-cycle response:
- commit_valid=1 and commit_pc = head pc in the same cycle;
- head advances one entry;
- if arch!=0, archi_X field arch <= phy at the edge, and rn_rst_mask sets bit (arch*RNDEPTH + old phy).
REQ-019 A branch head SHALL set brq_pop=1 in its commit cycle. With brq_misPredict=1 the branch SHALL still commit (rd updated as REQ-018), then flush=1, cause 01, flush_pc = head pc + 4.
REQ-020 Any abort SHALL:
- empty the ROB (head=tail) at the edge;
- enter FLUSH;
- set rn_rst_mask to all bits except, per arch register, the bit of its post-update mapping.
REQ-021 FLUSH SHALL last exactly one cycle with dsp_ready=0 and no commit, then return to RUN.
REQ-022 Simultaneous push and commit on a full ROB SHALL push only if not full at cycle start (no bypass). Simultaneous push and abort SHALL drop the push.
REQ-023 arch register 0 field SHALL never change and its bits SHALL never appear in rn_rst_mask.
REQ-024 flush, commit_valid, brq_pop and rn_rst_mask SHALL be 0 whenever no corresponding event occurs.

Reset
REQ-025 On RSTn low, the block SHALL asynchronously clear: ROB empty, state RUN, all archi_X fields 0, all combinational outputs 0, dsp_ready 1 after release.
REQ-026 Reset mid-operation SHALL discard all entries without emitting flush or masks.

Configuration
REQ-027 With COMMIT_PERF_CNT_EN defined, the block SHALL add outputs perf_retired (64) and perf_abort (32), reset 0, counting commits and aborts, wrapping on overflow. Without it, these ports SHALL not exist and no counters SHALL be built.

Verification
REQ-028 Push 3 entries arch 1,2,3 phy 1, set wbLog bits -> 3 commit pulses in 3 consecutive cycles; archi_X fields 1..3 = 1; masks clear bits 4,8,12.
REQ-029 Fill 8 entries -> dsp_ready=0; one commit -> dsp_ready=1 next cycle; wrap past index 7 preserves order.
REQ-030 Head branch pc 0x1000, brq_valid=1, brq_misPredict=1 -> brq_pop=1, commit_valid=1, flush cause 01, flush_pc 0x1004; ROB empty; dsp_ready=0 for one cycle.
REQ-031 isAsynExcept with head pc 0x2000 ready and same-cycle isSynExcept younger -> cause 11, flush_pc 0x2000, no commit.
REQ-032 RSTn low during a FLUSH cycle -> all outputs 0, state RUN, archi_X fields 0.
